// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter and sequencer sharing one single-port data memory between two masters.
// Each access takes an ACCESS cycle (grant + memory strobes) and a RESP cycle (response pulse).
module data_memory_arbiter #(
  parameter int unsigned MEMORY_SIZE = 4096,
  parameter int unsigned ADDR_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [31:0]           m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [31:0]           m0_rdata,
  output logic                  m0_err,

  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [31:0]           m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [31:0]           m1_rdata,
  output logic                  m1_err,

  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_write_data,
  input  logic [31:0]           mem_read_data
);

  localparam logic [ADDR_WIDTH-1:0] MemLimit = ADDR_WIDTH'(MEMORY_SIZE);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e state_q;
  logic   last_grant_q;  // 1: master 1 won last, so master 0 wins a tie
  logic   sel_q;         // master being served in ACCESS/RESP
  logic   we_q;
  logic   legal_q;

  logic                  any_req;
  logic                  pick_m1;
  logic                  win_we;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [31:0]           win_wdata;
  logic                  win_legal;

  always_comb begin
    any_req   = m0_req | m1_req;
    pick_m1   = (m0_req & m1_req) ? ~last_grant_q : m1_req;
    win_we    = pick_m1 ? m1_we    : m0_we;
    win_addr  = pick_m1 ? m1_addr  : m0_addr;
    win_wdata = pick_m1 ? m1_wdata : m0_wdata;
    win_legal = (win_addr[1:0] == 2'b00) && (win_addr < MemLimit);
  end

  // Every output is a register, so async reset clears strobes mid-ACCESS immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StIdle;
      last_grant_q   <= 1'b1;
      sel_q          <= 1'b0;
      we_q           <= 1'b0;
      legal_q        <= 1'b0;
      m0_gnt         <= 1'b0;
      m0_rvalid      <= 1'b0;
      m0_rdata       <= '0;
      m0_err         <= 1'b0;
      m1_gnt         <= 1'b0;
      m1_rvalid      <= 1'b0;
      m1_rdata       <= '0;
      m1_err         <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
    end else begin
      m0_gnt         <= 1'b0;
      m0_rvalid      <= 1'b0;
      m0_rdata       <= '0;
      m0_err         <= 1'b0;
      m1_gnt         <= 1'b0;
      m1_rvalid      <= 1'b0;
      m1_rdata       <= '0;
      m1_err         <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;

      unique case (state_q)
        StAccess: begin
          state_q <= StResp;
          if (sel_q) begin
            m1_rvalid <= 1'b1;
            m1_err    <= ~legal_q;
            m1_rdata  <= (legal_q && !we_q) ? mem_read_data : '0;
          end else begin
            m0_rvalid <= 1'b1;
            m0_err    <= ~legal_q;
            m0_rdata  <= (legal_q && !we_q) ? mem_read_data : '0;
          end
        end

        StIdle, StResp: begin
          if (any_req) begin
            state_q      <= StAccess;
            sel_q        <= pick_m1;
            last_grant_q <= pick_m1;
            we_q         <= win_we;
            legal_q      <= win_legal;
            m0_gnt       <= ~pick_m1;
            m1_gnt       <= pick_m1;
            if (win_legal) begin
              mem_read       <= ~win_we;
              mem_write      <= win_we;
              mem_address    <= {2'b00, win_addr[ADDR_WIDTH-1:2]};
              mem_write_data <= win_wdata;
            end
          end else begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Bench for data_memory_arbiter: directed vector table, hand sequences, and randomized traffic
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_data_memory_arbiter;

  localparam int unsigned MemSize = 4096;
  localparam int unsigned Words   = MemSize / 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_v   [2];
  logic        we_v    [2];
  logic [31:0] addr_v  [2];
  logic [31:0] wdata_v [2];

  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_address, mem_write_data, mem_read_data;

  data_memory_arbiter #(
    .MEMORY_SIZE (MemSize),
    .ADDR_WIDTH  (32)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .m0_req         (req_v[0]),
    .m0_we          (we_v[0]),
    .m0_addr        (addr_v[0]),
    .m0_wdata       (wdata_v[0]),
    .m0_gnt         (m0_gnt),
    .m0_rvalid      (m0_rvalid),
    .m0_rdata       (m0_rdata),
    .m0_err         (m0_err),
    .m1_req         (req_v[1]),
    .m1_we          (we_v[1]),
    .m1_addr        (addr_v[1]),
    .m1_wdata       (wdata_v[1]),
    .m1_gnt         (m1_gnt),
    .m1_rvalid      (m1_rvalid),
    .m1_rdata       (m1_rdata),
    .m1_err         (m1_err),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  function automatic logic [31:0] init_word(int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h0F0F_1234;
  endfunction

  // Stand-in for Data_Memory: combinational read, write on the clock edge.
  logic [31:0] mem_arr [Words];
  logic        mem_ready = 1'b0;
  assign mem_read_data = mem_arr[mem_address[9:0]];
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < Words; i++) mem_arr[i] <= init_word(i);
      mem_ready <= 1'b1;
    end else if (mem_write) begin
      mem_arr[mem_address[9:0]] <= mem_write_data;
    end
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Reference model: what the masters and memory should see after the next clock edge.
  logic [31:0] ref_mem [Words];
  logic        m_busy;  // a granted access is in its grant cycle
  int          m_sel, m_last;
  logic        m_we, m_legal;
  int          m_idx;
  logic [31:0] m_wdata;
  logic        exp_gnt [2], exp_rv [2], exp_err [2];
  logic [31:0] exp_rd [2];
  logic        exp_mr, exp_mw;
  logic [31:0] exp_ma, exp_mwd;

  task automatic clear_exp();
    for (int m = 0; m < 2; m++) begin
      exp_gnt[m] = 0; exp_rv[m] = 0; exp_err[m] = 0; exp_rd[m] = '0;
    end
    exp_mr = 0; exp_mw = 0; exp_ma = '0; exp_mwd = '0;
  endtask

  task automatic model_step();
    int w;
    if (!reset) begin
      clear_exp();
      m_busy = 0;
      m_last = 1;
    end
    chk("m0_gnt", 32'(m0_gnt), 32'(exp_gnt[0]));
    chk("m1_gnt", 32'(m1_gnt), 32'(exp_gnt[1]));
    chk("m0_rvalid", 32'(m0_rvalid), 32'(exp_rv[0]));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(exp_rv[1]));
    chk("m0_rdata", m0_rdata, exp_rd[0]);
    chk("m1_rdata", m1_rdata, exp_rd[1]);
    chk("m0_err", 32'(m0_err), 32'(exp_err[0]));
    chk("m1_err", 32'(m1_err), 32'(exp_err[1]));
    chk("mem_read", 32'(mem_read), 32'(exp_mr));
    chk("mem_write", 32'(mem_write), 32'(exp_mw));
    chk("mem_address", mem_address, exp_ma);
    chk("mem_write_data", mem_write_data, exp_mwd);
    if (!reset) return;
    clear_exp();
    if (m_busy) begin
      m_busy = 0;
      exp_rv[m_sel] = 1;
      if (!m_legal) exp_err[m_sel] = 1;
      else if (!m_we) exp_rd[m_sel] = ref_mem[m_idx];
      else ref_mem[m_idx] = m_wdata;
    end else if (req_v[0] || req_v[1]) begin
      if (req_v[0] && req_v[1]) w = (m_last == 0) ? 1 : 0;
      else w = req_v[1] ? 1 : 0;
      m_last  = w;
      m_sel   = w;
      m_busy  = 1;
      m_we    = we_v[w];
      m_legal = (addr_v[w] % 4 == 0) && (addr_v[w] < MemSize);
      m_idx   = int'(addr_v[w] / 4) % Words;
      m_wdata = wdata_v[w];
      exp_gnt[w] = 1;
      if (m_legal) begin
        exp_mr  = !m_we;
        exp_mw  = m_we;
        exp_ma  = addr_v[w] / 4;
        exp_mwd = m_wdata;
      end
    end
  endtask

  // One clock: model checks at the falling edge, stimulus continues 1ns after the rising edge.
  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic gnt_of(int m);
    return (m == 1) ? m1_gnt : m0_gnt;
  endfunction

  task automatic new_req(int m);
    req_v[m]   = 1'b1;
    we_v[m]    = 1'($urandom_range(0, 1));
    wdata_v[m] = $urandom;
    case ($urandom_range(0, 9))
      0:       addr_v[m] = 32'($urandom_range(0, Words - 1)) * 4 + 32'($urandom_range(1, 3));
      1:       addr_v[m] = MemSize + 32'($urandom_range(0, 100)) * 4;
      2:       addr_v[m] = $urandom;
      3:       addr_v[m] = MemSize - 4;
      default: addr_v[m] = 32'($urandom_range(0, 31)) * 4;
    endcase
  endtask

  typedef struct {
    int          mst;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_strobe;
    logic [31:0] exp_maddr;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl [6];

  task automatic run_txn(input vec_t v);
    int n;
    req_v[v.mst]   = 1'b1;
    we_v[v.mst]    = v.we;
    addr_v[v.mst]  = v.addr;
    wdata_v[v.mst] = v.wdata;
    n = 0;
    do begin
      tick();
      n++;
    end while (!gnt_of(v.mst) && n < 10);
    chk("txn_grant_latency", 32'(n), 32'd1);
    chk("txn_mem_read", 32'(mem_read), 32'(v.exp_strobe & !v.we));
    chk("txn_mem_write", 32'(mem_write), 32'(v.exp_strobe & v.we));
    chk("txn_mem_address", mem_address, v.exp_maddr);
    req_v[v.mst] = 1'b0;
    tick();
    chk("txn_rvalid", 32'((v.mst == 1) ? m1_rvalid : m0_rvalid), 32'd1);
    chk("txn_rdata", (v.mst == 1) ? m1_rdata : m0_rdata, v.exp_rdata);
    chk("txn_err", 32'((v.mst == 1) ? m1_err : m0_err), 32'(v.exp_err));
  endtask

  initial begin
    int gq[$];
    int prev;
    vec_t v6;

    for (int i = 0; i < Words; i++) ref_mem[i] = init_word(i);
    clear_exp();
    m_busy = 0;
    m_last = 1;
    m_sel  = 0;
    for (int m = 0; m < 2; m++) begin
      req_v[m] = 0; we_v[m] = 0; addr_v[m] = '0; wdata_v[m] = '0;
    end

    tbl[0] = '{0, 1'b1, 32'h10,   32'hDEAD_BEEF, 1'b1, 32'd4,    1'b0, 32'h0};
    tbl[1] = '{0, 1'b0, 32'h10,   32'h0,         1'b1, 32'd4,    1'b0, 32'hDEAD_BEEF};
    tbl[2] = '{1, 1'b0, 32'h13,   32'h0,         1'b0, 32'd0,    1'b1, 32'h0};
    tbl[3] = '{1, 1'b0, MemSize,  32'h0,         1'b0, 32'd0,    1'b1, 32'h0};
    tbl[4] = '{1, 1'b1, 32'hFFC,  32'h1234_5678, 1'b1, 32'd1023, 1'b0, 32'h0};
    tbl[5] = '{1, 1'b0, 32'hFFC,  32'h0,         1'b1, 32'd1023, 1'b0, 32'h1234_5678};

    // Reset for 3 cycles, then idle with no requests.
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
    chk("idle_strobes", 32'({mem_read, mem_write}), 32'd0);

    // Both masters hold read requests: grants must alternate starting with master 0.
    req_v[0] = 1; we_v[0] = 0; addr_v[0] = 32'h0;
    req_v[1] = 1; we_v[1] = 0; addr_v[1] = 32'h4;
    prev = -1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (prev >= 0) chk("contend_rvalid", 32'((prev == 1) ? m1_rvalid : m0_rvalid), 32'd1);
      prev = -1;
      if (m0_gnt) begin gq.push_back(0); prev = 0; end
      if (m1_gnt) begin gq.push_back(1); prev = 1; end
    end
    req_v[0] = 0;
    req_v[1] = 0;
    chk("contend_gnt_count", 32'(gq.size()), 32'd4);
    for (int i = 0; i < 4; i++) chk("contend_gnt_order", 32'((i < gq.size()) ? gq[i] : -1), 32'(i % 2));
    repeat (2) tick();

    for (int i = 0; i < 6; i++) run_txn(tbl[i]);
    tick();

    // Reset mid-ACCESS of a write: strobe drops at once, no response, memory unchanged.
    req_v[0] = 1; we_v[0] = 1; addr_v[0] = 32'h20; wdata_v[0] = 32'hCAFE_F00D;
    tick();
    chk("abort_gnt_seen", 32'(m0_gnt), 32'd1);
    chk("abort_write_seen", 32'(mem_write), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("abort_write_drop", 32'(mem_write), 32'd0);
    chk("abort_gnt_drop", 32'(m0_gnt), 32'd0);
    req_v[0] = 0;
    repeat (2) begin
      tick();
      chk("abort_no_rvalid", 32'(m0_rvalid), 32'd0);
    end
    reset = 1'b1;
    tick();
    v6 = '{0, 1'b0, 32'h20, 32'h0, 1'b1, 32'd8, 1'b0, init_word(8)};
    run_txn(v6);

    // Randomized traffic from both masters, obeying hold-until-grant.
    for (int c = 0; c < 600; c++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        if (req_v[m] && gnt_of(m)) begin
          if ($urandom_range(0, 1) == 1) new_req(m);
          else req_v[m] = 1'b0;
        end else if (!req_v[m] && $urandom_range(0, 3) == 0) begin
          new_req(m);
        end
      end
    end
    req_v[0] = 0;
    req_v[1] = 0;
    repeat (4) tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
